// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB completer definitions: FSM state type, standard window bases,
// window geometry, ID word offset and the PSLVERR response encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_t;

   localparam logic [31:0] SLV0_BASE    = 32'h0001_F000;
   localparam logic [31:0] SLV1_BASE    = 32'h0002_F000;
   localparam int          WINDOW_BYTES = 4096;
   localparam logic [11:0] ID_OFFSET    = 12'hFFC;

   localparam logic APB_OKAY = 1'b0;
   localparam logic APB_ERR  = 1'b1;

   // Wait-state counter width; covers WAIT_STATES 0..15.
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_mem_array.sv
// -----------------------------------------------------------------------------
// apb_slave_mem_array
// Word storage behind the APB window: 1023 x 32 synchronous RAM. The last
// word slot of the 4 KB window is the read-only ID word and has no storage.
// Ports:
//   clk        clock
//   i_rd_en    capture word i_rd_addr into o_rd_data on this edge
//   i_rd_addr  word index for reads
//   o_rd_data  registered read data
//   i_wr_en    commit write on this edge
//   i_wr_addr  word index for writes
//   i_wr_data  write data
//   i_wr_strb  per-byte write enables
// -----------------------------------------------------------------------------
module apb_slave_mem_array
   import apb_pkg::*;
#(
   parameter int DEPTH = WINDOW_BYTES / 4 - 1
) (
   input  logic        clk,
   input  logic        i_rd_en,
   input  logic [9:0]  i_rd_addr,
   output logic [31:0] o_rd_data,
   input  logic        i_wr_en,
   input  logic [9:0]  i_wr_addr,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_wr_strb
);

   logic [31:0] r_mem [0:DEPTH-1];
   logic [31:0] r_rd_data;

   always_ff @(posedge clk) begin
      // Index DEPTH is the ID slot; the caller never writes it, and the guard
      // keeps an accidental access from touching a non-existent word.
      if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wr_strb[b]) begin
               r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
         end
      end
      if (i_rd_en) begin
         r_rd_data <= (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB4 completer for one 4 KB window at BASE_ADDR: byte-strobed word storage,
// read-only ID word at offset 0xFFC, WAIT_STATES extra access cycles and
// PSLVERR for out-of-window, misaligned and ID-write transfers.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   psel_i           APB select
//   penable_i        APB enable (access phase)
//   pwrite_i         1 = write, 0 = read
//   paddr_i          byte address
//   pwdata_i         write data
//   pstrb_i          write byte strobes
//   pready_o         transfer complete
//   prdata_o         read data (zero unless completing a clean read)
//   pslverr_o        error response (only while pready_o = 1)
// -----------------------------------------------------------------------------
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(SLV0_BASE),
   parameter int                    WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'h5A5A_0001)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [DATA_WIDTH-1:0] pwdata_i,
   input  logic [3:0]            pstrb_i,
   output logic                  pready_o,
   output logic [DATA_WIDTH-1:0] prdata_o,
   output logic                  pslverr_o
);

   apb_slv_state_t        r_state;
   apb_slv_state_t        w_next_state;
   logic [WAIT_CNT_W-1:0] r_cnt;
   logic                  r_write;
   logic                  r_err;
   logic                  r_is_id;
   logic [9:0]            r_word;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_strb;

   logic                  w_accept;
   logic                  w_err;
   logic                  w_id_hit;
   logic                  w_ready;
   logic                  w_complete;
   logic                  w_commit;
   logic [DATA_WIDTH-1:0] w_ram_rdata;

   // Setup cycles are only recognised from IDLE; penable_i alone is ignored.
   assign w_accept = (r_state == IDLE) && psel_i && !penable_i;
   assign w_id_hit = (paddr_i[11:0] == ID_OFFSET);
   assign w_err    = ((paddr_i[ADDR_WIDTH-1:12] != BASE_ADDR[ADDR_WIDTH-1:12]) ||
                      (paddr_i[1:0] != 2'b00) ||
                      (pwrite_i && w_id_hit)) ? APB_ERR : APB_OKAY;

   assign w_ready    = (r_state == ACCESS) && (r_cnt == '0);
   assign w_complete = w_ready && psel_i && penable_i;
   assign w_commit   = w_complete && r_write && (r_err == APB_OKAY);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; dropping psel_i mid-ACCESS aborts the transfer.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = ACCESS;
         ACCESS:  if (!psel_i || w_complete) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Transfer control captured at setup; the counter only runs while the
   // bus is actually in its access phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_err   <= APB_OKAY;
         r_is_id <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= WAIT_CNT_W'(WAIT_STATES);
         r_write <= pwrite_i;
         r_err   <= w_err;
         r_is_id <= w_id_hit && !pwrite_i;
      end else if ((r_state == ACCESS) && psel_i && penable_i && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Write payload: held for the whole access phase, later bus changes ignored.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_word  <= paddr_i[11:2];
         r_wdata <= pwdata_i;
         r_strb  <= pstrb_i;
      end
   end

   apb_slave_mem_array u_array (
      .clk       (clk),
      .i_rd_en   (w_accept && !pwrite_i),
      .i_rd_addr (paddr_i[11:2]),
      .o_rd_data (w_ram_rdata),
      .i_wr_en   (w_commit),
      .i_wr_addr (r_word),
      .i_wr_data (r_wdata),
      .i_wr_strb (r_strb)
   );

   // Outputs: data and error only shown in the completing cycle.
   always_comb begin
      pready_o  = w_ready;
      prdata_o  = '0;
      pslverr_o = APB_OKAY;
      if (w_ready) begin
         pslverr_o = r_err;
         if (!r_write && (r_err == APB_OKAY)) begin
            prdata_o = r_is_id ? ID_VALUE : w_ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pready;
   logic [2:0]  pslverr;
   logic [31:0] prdata0, prdata1, prdata2;

   always #5 clk = ~clk;

   // index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3
   apb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .psel_i(psel[0]), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready[0]), .prdata_o(prdata0), .pslverr_o(pslverr[0]));
   apb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .psel_i(psel[1]), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready[1]), .prdata_o(prdata1), .pslverr_o(pslverr[1]));
   apb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .psel_i(psel[2]), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready[2]), .prdata_o(prdata2), .pslverr_o(pslverr[2]));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic logic [31:0] rd_of(input int idx);
      case (idx)
         0:       return prdata0;
         1:       return prdata1;
         default: return prdata2;
      endcase
   endfunction

   function automatic int ws_of(input int idx);
      case (idx)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transfer; the expected response is queued when the setup
   // phase is driven and retired when the selected slave raises pready.
   task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
      exp_t e;
      int   cyc;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = ws_of(idx) + 1;
      e.tag   = tag;
      sb.push_back(e);
      @(negedge clk);
      psel      = 3'b000;
      psel[idx] = 1'b1;
      penable   = 1'b0;
      pwrite    = wr;
      paddr     = addr;
      pwdata    = wd;
      pstrb     = st;
      @(negedge clk);
      penable = 1'b1;
      cyc     = 1;
      while (!pready[idx] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      check32({e.tag, "_ready"}, {31'b0, pready[idx]}, 32'd1);
      if (pready[idx]) begin
         check32({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
         check32({e.tag, "_rdata"}, rd_of(idx), e.rdata);
         check32({e.tag, "_err"}, {31'b0, pslverr[idx]}, {31'b0, e.err});
      end else begin
         psel    = 3'b000;
         penable = 1'b0;
      end
   endtask

   task automatic bus_idle();
      @(negedge clk);
      psel    = 3'b000;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      psel    = 3'b000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      repeat (2) @(negedge clk);
      check32("rst_pready", {29'b0, pready}, 32'd0);
      check32("rst_pslverr", {29'b0, pslverr}, 32'd0);
      check32("rst_prdata0", prdata0, 32'd0);
      check32("rst_prdata1", prdata1, 32'd0);
      check32("rst_prdata2", prdata2, 32'd0);
      rst_n = 1'b1;

      // penable without a setup phase must not start a transfer
      @(negedge clk);
      psel    = 3'b001;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 32'h0001_F010;
      repeat (2) @(negedge clk);
      check32("idle_penable", {31'b0, pready[0]}, 32'd0);
      psel    = 3'b000;
      penable = 1'b0;

      // no-wait slave: write then read
      xfer(0, 1'b1, 32'h0001_F010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "ws0_wr");
      xfer(0, 1'b0, 32'h0001_F010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ws0_rd");

      // error responses
      xfer(0, 1'b1, 32'h0001_F000, 32'h0102_0304, 4'hF, 32'h0, 1'b0, "pre_f000");
      xfer(0, 1'b0, 32'h0003_0000, 32'h0, 4'h0, 32'h0, 1'b1, "err_oow");
      xfer(0, 1'b1, 32'h0001_F002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "err_misal");
      xfer(0, 1'b0, 32'h0001_F000, 32'h0, 4'h0, 32'h0102_0304, 1'b0, "misal_keep");
      xfer(0, 1'b1, 32'h0001_FFFC, 32'h1234_5678, 4'hF, 32'h0, 1'b1, "err_id_wr");
      xfer(0, 1'b0, 32'h0001_FFFC, 32'h0, 4'h0, 32'h5A5A_0001, 1'b0, "id_rd");
      bus_idle();

      // three wait states
      xfer(2, 1'b1, 32'h0001_F000, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0, "ws3_pre");
      xfer(2, 1'b0, 32'h0001_F000, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, "ws3_rd");
      bus_idle();

      // byte strobes, including an all-zero strobe
      xfer(1, 1'b1, 32'h0001_F020, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "strb_pre");
      xfer(1, 1'b1, 32'h0001_F020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "strb_wr");
      xfer(1, 1'b0, 32'h0001_F020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "strb_rd");
      xfer(1, 1'b1, 32'h0001_F020, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "strb0_wr");
      xfer(1, 1'b0, 32'h0001_F020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "strb0_rd");

      // back-to-back transfers with no idle cycle between them
      xfer(1, 1'b1, 32'h0001_F040, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, "b2b_wr0");
      xfer(1, 1'b0, 32'h0001_F040, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, "b2b_rd0");
      xfer(1, 1'b1, 32'h0001_F044, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, "b2b_wr1");
      xfer(1, 1'b0, 32'h0001_F044, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, "b2b_rd1");
      bus_idle();

      // psel dropped mid-access on a write
      xfer(2, 1'b1, 32'h0001_F030, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "abort_pre");
      bus_idle();
      @(negedge clk);
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0001_F030;
      pwdata  = 32'h1234_5678;
      pstrb   = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel    = 3'b000;
      penable = 1'b0;
      @(negedge clk);
      check32("abort_rdy", {31'b0, pready[2]}, 32'd0);
      xfer(2, 1'b0, 32'h0001_F030, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, "abort_keep");
      bus_idle();

      // reset during a wait state drops the pending write
      xfer(2, 1'b1, 32'h0001_F034, 32'h7654_3210, 4'hF, 32'h0, 1'b0, "rst_pre");
      bus_idle();
      @(negedge clk);
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0001_F034;
      pwdata  = 32'hFFFF_0000;
      pstrb   = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check32("rst_mid_pready", {29'b0, pready}, 32'd0);
      check32("rst_mid_pslverr", {29'b0, pslverr}, 32'd0);
      check32("rst_mid_prdata2", prdata2, 32'd0);
      @(negedge clk);
      psel    = 3'b000;
      penable = 1'b0;
      rst_n   = 1'b1;
      xfer(2, 1'b0, 32'h0001_F034, 32'h0, 4'h0, 32'h7654_3210, 1'b0, "rst_keep");
      xfer(2, 1'b1, 32'h0001_F038, 32'h0000_00A5, 4'h1, 32'h0, 1'b0, "post_rst_wr");
      bus_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB4 completer that answers the APB transfers issued by the bridge's master side.
- Models one 4 KB peripheral window, default 0x0001_F000–0x0001_FFFF; a second instance covers 0x0002_F000 via BASE_ADDR.
- Provides word-addressed storage with byte strobes, a read-only ID word, programmable wait states and PSLVERR generation.
- Serves as the bridge's system-level slave and as the verification target for burst address sequencing.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (fixed 32; other values unsupported)
BASE_ADDR, 32'h0001_F000, window base, 4 KB aligned
WAIT_STATES, 1, extra access-phase cycles before PREADY (0..15)
ID_VALUE, 32'h5A5A_0001, constant returned at offset 0xFFC

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1=write, 0=read
paddr_i  in  ADDR_WIDTH  byte address
pwdata_i  in  DATA_WIDTH  write data
pstrb_i  in  4  write byte strobes
pready_o  out  1  transfer complete
prdata_o  out  DATA_WIDTH  read data, valid only while pready_o=1
pslverr_o  out  1  error response, valid only while pready_o=1

Behaviour:
- Reset values: state IDLE, wait counter 0, pready_o=0, prdata_o=0, pslverr_o=0. RAM contents are not reset; ID word is constant.
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS on psel_i=1 && penable_i=0 (setup cycle). At that edge, latch:
  - addr, pwrite, wdata, strb;
  - counter = WAIT_STATES;
  - err flag;
  - read word (RAM or ID) into rdata register.
- err flag is set when any of these hold:
  - paddr_i[ADDR_WIDTH-1:12] != BASE_ADDR[ADDR_WIDTH-1:12];
  - paddr_i[1:0] != 0;
  - write to offset 0xFFC.
- ACCESS, penable_i=1, counter!=0: decrement counter; pready_o=0.
- ACCESS, counter==0: pready_o=1 (combinational from state and counter).
  - prdata_o = rdata on a clean read; 0 on writes or error.
  - pslverr_o = err flag.
- Completing edge (pready_o=1, psel_i=1, penable_i=1):
  - clean write: commit bytes where strb=1 into word addr[11:2];
  - go to IDLE.
- Latency from setup cycle to completion: 1+WAIT_STATES cycles. WAIT_STATES=0 gives no-wait APB.
- Back-to-back: a new setup cycle directly following completion is accepted from IDLE. No idle cycle is required between transfers.
- Read of offset 0xFFC returns ID_VALUE, pslverr_o=0.
- Error transfers never modify storage. Out-of-window reads return 0.
- pstrb_i=0 on a clean write: completes OKAY, no bytes change.
- Protocol violation (psel_i deasserted while in ACCESS): abort to IDLE, no write, pready_o stays 0.
- penable_i=1 while IDLE: ignored.
- Reset mid-ACCESS: immediate return to IDLE and outputs to reset values; the pending write is dropped.
- The latched address is used throughout ACCESS; paddr_i changes after setup are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_slv_state_t;
  - localparams SLV0_BASE=32'h0001_F000, SLV1_BASE=32'h0002_F000, WINDOW_BYTES=4096, ID_OFFSET=12'hFFC;
  - APB_OKAY/APB_ERR constants.
- One sub-module, apb_slave_mem_array:
  - 1023x32 synchronous RAM with a 4-bit byte-write enable;
  - one read port, read-on-setup;
  - one write port, write-on-complete.

Test Plan:
- WAIT_STATES=0: write 0xDEAD_BEEF to 0x0001_F010 with pstrb=4'hF, then read it -> pready_o high in first access cycle; read prdata_o=0xDEAD_BEEF, pslverr_o=0.
- WAIT_STATES=3: read 0x0001_F000 -> pready_o low 3 access cycles, high on 4th; completion 4 cycles after setup.
- Byte strobes: preload 0x1122_3344 at 0x0001_F020, write 0xAABB_CCDD with pstrb=4'b0101 -> readback 0x11BB_33DD.
- Errors:
  - read 0x0003_0000 -> pslverr_o=1, prdata_o=0;
  - write 0x0001_F002 -> pslverr_o=1, word unchanged;
  - write 0x0001_FFFC -> pslverr_o=1, readback ID_VALUE.
- Back-to-back: write, read, write with no idle cycles and WAIT_STATES=1 -> each completes in 2 cycles; data is consistent.
- Aborts:
  - psel_i dropped mid-ACCESS on a write -> no update, FSM in IDLE next cycle;
  - rst_n asserted during a wait state -> pready_o=0 immediately, following transfer behaves normally.
